// File: rtl/cd_mailbox_bridge.sv
// Mailbox bridge between the HPS extension endpoint (cd_out/cd_in) and the CD-ROM drive core.
// Optional build macro CD_MAILBOX_OVERRUN_CNT_EN adds the saturating cmd_overrun_cnt output.
module cd_mailbox_bridge #(
   parameter int STAT_DEPTH  = 4,
   parameter int HOLD_CYCLES = 64
) (
   input  logic         clk_sys,
   input  logic         reset_n,
   input  logic [112:0] cd_out,
   output logic [112:0] cd_in,
   output logic [111:0] cmd_data,
   output logic         cmd_valid,
   input  logic         cmd_ready,
   input  logic [111:0] stat_data,
   input  logic         stat_valid,
   output logic         stat_ready,
   output logic         cmd_overrun,
`ifdef CD_MAILBOX_OVERRUN_CNT_EN
   output logic [7:0]   cmd_overrun_cnt,
`endif
   input  logic         cmd_overrun_clr
);

   localparam int PTR_W = $clog2(STAT_DEPTH);
   localparam int TMR_W = $clog2(HOLD_CYCLES + 1);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   logic                armed;
   logic                prev_tog;
   logic                cmd_event;
   logic                cmd_load;
   logic                cmd_drop;
   logic                cmd_consume;

   logic [111:0]        stat_mem [STAT_DEPTH];
   logic [PTR_W:0]      wr_ptr;
   logic [PTR_W:0]      rd_ptr;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;

   state_t              state;
   state_t              state_nxt;
   logic [TMR_W-1:0]    timer;
   logic [TMR_W-1:0]    timer_nxt;
   logic [112:0]        cd_in_nxt;

   // Command path: the first edge out of reset only samples the toggle level
   assign cmd_event   = armed && (cd_out[112] != prev_tog);
   assign cmd_consume = cmd_valid && cmd_ready;
   assign cmd_load    = cmd_event && (!cmd_valid || cmd_ready);
   assign cmd_drop    = cmd_event && cmd_valid && !cmd_ready;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         armed       <= 1'b0;
         prev_tog    <= 1'b0;
         cmd_data    <= '0;
         cmd_valid   <= 1'b0;
         cmd_overrun <= 1'b0;
      end else begin
         armed    <= 1'b1;
         prev_tog <= cd_out[112];
         if (cmd_load) begin
            cmd_data  <= cd_out[111:0];
            cmd_valid <= 1'b1;
         end else if (cmd_consume) begin
            cmd_valid <= 1'b0;
         end
         if (cmd_drop) begin
            cmd_overrun <= 1'b1;
         end else if (cmd_overrun_clr) begin
            cmd_overrun <= 1'b0;
         end
      end
   end

`ifdef CD_MAILBOX_OVERRUN_CNT_EN
   // A drop coinciding with a clear restarts the count at one
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cmd_overrun_cnt <= '0;
      end else if (cmd_drop) begin
         if (cmd_overrun_clr) begin
            cmd_overrun_cnt <= 8'd1;
         end else if (cmd_overrun_cnt != 8'hFF) begin
            cmd_overrun_cnt <= cmd_overrun_cnt + 8'd1;
         end
      end else if (cmd_overrun_clr) begin
         cmd_overrun_cnt <= '0;
      end
   end
`endif

   // Status FIFO: the extra pointer bit separates full from empty
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign stat_ready = !fifo_full;
   assign push       = stat_valid && !fifo_full;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) begin
         stat_mem[wr_ptr[PTR_W-1:0]] <= stat_data;
      end
   end

   // Presenter: each word stays on cd_in for at least HOLD_CYCLES edges
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         timer <= '0;
         cd_in <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         cd_in <= cd_in_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      cd_in_nxt = cd_in;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               cd_in_nxt = {~cd_in[112], stat_mem[rd_ptr[PTR_W-1:0]]};
               timer_nxt = TMR_W'(HOLD_CYCLES - 1);
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (timer == '0) begin
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - TMR_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cd_mailbox_bridge.sv
// Directed bench for cd_mailbox_bridge (STAT_DEPTH=4, HOLD_CYCLES=4); overrun counter checks
// are included when CD_MAILBOX_OVERRUN_CNT_EN is defined.
module tb_cd_mailbox_bridge;

   logic         clk_sys;
   logic         reset_n;
   logic [112:0] cd_out;
   logic [112:0] cd_in;
   logic [111:0] cmd_data;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [111:0] stat_data;
   logic         stat_valid;
   logic         stat_ready;
   logic         cmd_overrun;
   logic         cmd_overrun_clr;
`ifdef CD_MAILBOX_OVERRUN_CNT_EN
   logic [7:0]   cmd_overrun_cnt;
`endif

   int vectors;
   int miscompares;

   localparam logic [111:0] W1 = 112'h1234_5678_9ABC;
   localparam logic [111:0] W2 = 112'hAAAA_0000_1111_2222;
   localparam logic [111:0] W3 = 112'h3333_4444_5555;
   localparam logic [111:0] W4 = 112'hDEAD_BEEF_0042;
   localparam logic [111:0] W5 = 112'h0F0F_F0F0_7777;

   logic [111:0] words [6];

   cd_mailbox_bridge #(
      .STAT_DEPTH  (4),
      .HOLD_CYCLES (4)
   ) dut (
      .clk_sys         (clk_sys),
      .reset_n         (reset_n),
      .cd_out          (cd_out),
      .cd_in           (cd_in),
      .cmd_data        (cmd_data),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .stat_data       (stat_data),
      .stat_valid      (stat_valid),
      .stat_ready      (stat_ready),
      .cmd_overrun     (cmd_overrun),
`ifdef CD_MAILBOX_OVERRUN_CNT_EN
      .cmd_overrun_cnt (cmd_overrun_cnt),
`endif
      .cmd_overrun_clr (cmd_overrun_clr)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int idx;
      logic tog;
      vectors         = 0;
      miscompares     = 0;
      words[0] = 112'hA0A0_0001;
      words[1] = 112'hB0B0_0002;
      words[2] = 112'hC0C0_0003;
      words[3] = 112'hD0D0_0004;
      words[4] = 112'hE0E0_0005;
      words[5] = 112'hF0F0_0006;
      reset_n         = 1'b0;
      cd_out          = {1'b1, 112'h0};
      cmd_ready       = 1'b0;
      stat_data       = '0;
      stat_valid      = 1'b0;
      cmd_overrun_clr = 1'b0;
      step();
      step();
      chk("rst_cd_in", 128'(cd_in), 128'h0);
      chk("rst_cmd_valid", 128'(cmd_valid), 128'h0);
      chk("rst_cmd_data", 128'(cmd_data), 128'h0);
      chk("rst_overrun", 128'(cmd_overrun), 128'h0);
      chk("rst_stat_ready", 128'(stat_ready), 128'h1);
`ifdef CD_MAILBOX_OVERRUN_CNT_EN
      chk("rst_ovr_cnt", 128'(cmd_overrun_cnt), 128'h0);
`endif

      // stale toggle level high through reset release
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("arm_no_valid", 128'(cmd_valid), 128'h0);
         chk("arm_no_overrun", 128'(cmd_overrun), 128'h0);
      end

      cd_out = {1'b0, W1};
      step();
      chk("cmd1_valid", 128'(cmd_valid), 128'h1);
      chk("cmd1_data", 128'(cmd_data), 128'(W1));
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      chk("consume_valid", 128'(cmd_valid), 128'h0);
      chk("consume_data_hold", 128'(cmd_data), 128'(W1));

      cd_out = {1'b1, W2};
      step();
      chk("cmd2_valid", 128'(cmd_valid), 128'h1);
      chk("cmd2_data", 128'(cmd_data), 128'(W2));
      cd_out = {1'b0, W3};
      step();
      chk("drop_data", 128'(cmd_data), 128'(W2));
      chk("drop_overrun", 128'(cmd_overrun), 128'h1);
      chk("drop_valid", 128'(cmd_valid), 128'h1);
      cd_out    = {1'b1, W4};
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      chk("swap_data", 128'(cmd_data), 128'(W4));
      chk("swap_valid", 128'(cmd_valid), 128'h1);
      chk("swap_overrun_sticky", 128'(cmd_overrun), 128'h1);
      cmd_overrun_clr = 1'b1;
      step();
      cmd_overrun_clr = 1'b0;
      chk("clr_overrun", 128'(cmd_overrun), 128'h0);
      cd_out          = {1'b0, W5};
      cmd_overrun_clr = 1'b1;
      step();
      cmd_overrun_clr = 1'b0;
      chk("clr_vs_set", 128'(cmd_overrun), 128'h1);
      chk("clr_vs_set_data", 128'(cmd_data), 128'(W4));

`ifdef CD_MAILBOX_OVERRUN_CNT_EN
      cmd_overrun_clr = 1'b1;
      step();
      cmd_overrun_clr = 1'b0;
      chk("cnt_clr0", 128'(cmd_overrun_cnt), 128'h0);
      for (int i = 0; i < 300; i++) begin
         cd_out[112] = ~cd_out[112];
         step();
      end
      chk("cnt_sat", 128'(cmd_overrun_cnt), 128'd255);
      cmd_overrun_clr = 1'b1;
      step();
      cmd_overrun_clr = 1'b0;
      chk("cnt_clr", 128'(cmd_overrun_cnt), 128'h0);
      for (int i = 0; i < 2; i++) begin
         cd_out[112] = ~cd_out[112];
         step();
      end
      chk("cnt_two", 128'(cmd_overrun_cnt), 128'd2);
      cd_out[112]     = ~cd_out[112];
      cmd_overrun_clr = 1'b1;
      step();
      cmd_overrun_clr = 1'b0;
      chk("cnt_inc_wins", 128'(cmd_overrun_cnt), 128'd1);
`endif

      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      chk("final_consume", 128'(cmd_valid), 128'h0);

      // Status stream: A..E back-to-back, then F held against a full FIFO
      for (int k = 1; k <= 32; k++) begin
         stat_valid = (k <= 8);
         stat_data  = words[(k - 1 < 5) ? k - 1 : 5];
         step();
         if (k >= 2) begin
            idx = (k - 2) / 5;
            if (idx > 5) idx = 5;
            tog = ~idx[0];
            chk($sformatf("cd_in_k%0d", k), 128'(cd_in), 128'({tog, words[idx]}));
         end else begin
            chk("cd_in_k1", 128'(cd_in), 128'h0);
         end
         chk($sformatf("stat_ready_k%0d", k), 128'(stat_ready),
             128'((k == 5 || k == 6 || k == 8 || k == 9 || k == 10 || k == 11) ? 1'b0 : 1'b1));
      end
      stat_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("cd_in_hold_last", 128'(cd_in), 128'({1'b0, words[5]}));

      // Reset mid-operation drops queued status and pending command
      stat_valid = 1'b1;
      stat_data  = 112'h5A5A;
      step();
      stat_data  = 112'h6B6B;
      step();
      stat_valid = 1'b0;
      cd_out[112] = ~cd_out[112];
      step();
      chk("pre_reset_valid", 128'(cmd_valid), 128'h1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_cd_in", 128'(cd_in), 128'h0);
      chk("async_rst_valid", 128'(cmd_valid), 128'h0);
      chk("async_rst_ready", 128'(stat_ready), 128'h1);
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("post_rst_cd_in", 128'(cd_in), 128'h0);
      chk("post_rst_no_cmd", 128'(cmd_valid), 128'h0);
      cd_out = {~cd_out[112], W3};
      step();
      chk("post_rst_cmd_valid", 128'(cmd_valid), 128'h1);
      chk("post_rst_cmd_data", 128'(cmd_data), 128'(W3));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
